// File: rtl/sram_like_if.sv
// SRAM-like single-port bus between one master and one responder.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave_mem.sv
// SRAM-like responder backed by a word-organised memory, with configurable
// address-accept and data-return latencies; one transaction outstanding.
//
// state     | meaning
// IDLE      | no request in flight; addr_ok follows req when ADDR_LAT=0
// ADDR_WAIT | request seen, counting down before addr_ok
// DATA_WAIT | handshake done, counting down to the data_ok edge
module sram_like_slave_mem #(
  parameter int ADDR_WIDTH = 12,
  parameter int ADDR_LAT   = 0,
  parameter int DATA_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  sram_like_if.slave  bus
);

  localparam int LAT_MAX = (ADDR_LAT > DATA_LAT) ? ADDR_LAT : DATA_LAT;
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

  typedef enum logic [1:0] {IDLE, ADDR_WAIT, DATA_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic [31:0]       rword_q, rword_d;

  logic [31:0]           mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem_word;
  logic [3:0]            be;
  logic                  addr_ok_c;
  logic                  hs;
  logic                  unused_addr_bits;

  assign idx              = bus.addr[ADDR_WIDTH+1:2];
  assign mem_word         = mem_q[idx];
  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];
  assign hs               = addr_ok_c & ~rst;

  assign bus.addr_ok = hs;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

  always_comb begin
    be = 4'b0000;
    case (bus.size)
      2'd0:    be[bus.addr[1:0]] = 1'b1;
      2'd1:    be = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    rd_pend_d = rd_pend_q;
    rword_d   = rword_q;
    addr_ok_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (ADDR_LAT == 0) begin
          addr_ok_c = bus.req;
        end else if (bus.req) begin
          state_d = ADDR_WAIT;
          cnt_d   = CNT_W'(ADDR_LAT - 1);
        end
      end
      ADDR_WAIT: begin
        if (!bus.req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          addr_ok_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA_WAIT: begin
        // cnt_q counts edges still to go; the edge seen at 1 delivers data_ok
        if (cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          data_ok_d = 1'b1;
          if (rd_pend_q) rdata_d = rword_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (addr_ok_c) begin
      if (DATA_LAT <= 1) begin
        state_d   = IDLE;
        cnt_d     = '0;
        data_ok_d = 1'b1;
        if (!bus.wr) rdata_d = mem_word;
      end else begin
        state_d   = DATA_WAIT;
        cnt_d     = CNT_W'(DATA_LAT - 1);
        rd_pend_d = ~bus.wr;
        rword_d   = mem_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
      rword_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      rd_pend_q <= rd_pend_d;
      rword_q   <= rword_d;
    end
  end

  // Memory contents survive reset; only a completed handshake writes.
  always_ff @(posedge clk) begin
    if (hs && bus.wr) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= bus.wdata[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_slave_mem.sv
// Bench for sram_like_slave_mem: three instances with different latencies,
// directed scenarios plus randomized traffic against a behavioural model.
module tb_sram_like_slave_mem;

  localparam int NI = 3;
  localparam int AW = 12;

  function automatic int al_of(input int k);
    case (k)
      0: return 0;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int dl_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        b_rst   [NI];
  logic        b_req   [NI];
  logic        b_wr    [NI];
  logic [1:0]  b_size  [NI];
  logic [31:0] b_addr  [NI];
  logic [31:0] b_wdata [NI];
  logic        aok     [NI];
  logic        dok     [NI];
  logic [31:0] rd      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_like_if bus ();
    assign bus.req   = b_req[g];
    assign bus.wr    = b_wr[g];
    assign bus.size  = b_size[g];
    assign bus.addr  = b_addr[g];
    assign bus.wdata = b_wdata[g];
    assign aok[g]    = bus.addr_ok;
    assign dok[g]    = bus.data_ok;
    assign rd[g]     = bus.rdata;
    sram_like_slave_mem #(
      .ADDR_WIDTH (AW),
      .ADDR_LAT   (al_of(g)),
      .DATA_LAT   (dl_of(g))
    ) u_dut (
      .clk (clk),
      .rst (b_rst[g]),
      .bus (bus)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: requests wait ADDR_LAT cycles of continuous req while
  // nothing is outstanding; a response appears DATA_LAT cycles after handshake.
  logic [31:0] mm     [NI][1<<AW];
  int          attempt[NI];
  bit          pend_v [NI];
  int          pend_c [NI];
  bit          pend_w [NI];
  logic [31:0] pend_d [NI];
  bit          e_dok  [NI];
  logic [31:0] e_rd   [NI];

  task automatic model_step(input int k);
    bit          e_aok;
    bit          busy;
    bit          nxt_dok;
    int          i;
    bit          en;
    logic [31:0] a;
    if (b_rst[k]) begin
      attempt[k] = 0;
      pend_v[k]  = 0;
      e_dok[k]   = 0;
      e_rd[k]    = '0;
      check($sformatf("reset_addr_ok[%0d]", k), 32'(aok[k]), 32'd0);
      check($sformatf("reset_data_ok[%0d]", k), 32'(dok[k]), 32'd0);
      check($sformatf("reset_rdata[%0d]", k), rd[k], 32'd0);
      return;
    end
    busy  = pend_v[k];
    e_aok = b_req[k] && !busy && (attempt[k] >= al_of(k));
    check($sformatf("addr_ok[%0d]", k), 32'(aok[k]), 32'(e_aok));
    check($sformatf("data_ok[%0d]", k), 32'(dok[k]), 32'(e_dok[k]));
    check($sformatf("rdata[%0d]", k), rd[k], e_rd[k]);

    nxt_dok = 0;
    if (pend_v[k]) begin
      pend_c[k]--;
      if (pend_c[k] == 0) begin
        nxt_dok   = 1;
        pend_v[k] = 0;
        if (!pend_w[k]) e_rd[k] = pend_d[k];
      end
    end
    if (busy)          attempt[k] = 0;
    else if (b_req[k]) attempt[k] = e_aok ? 0 : attempt[k] + 1;
    else               attempt[k] = 0;

    if (e_aok) begin
      a = b_addr[k];
      i = int'(a[AW+1:2]);
      pend_d[k] = mm[k][i];
      if (b_wr[k]) begin
        for (int l = 0; l < 4; l++) begin
          case (b_size[k])
            2'd0:    en = (l == int'(a[1:0]));
            2'd1:    en = ((l / 2) == int'(a[1]));
            default: en = 1;
          endcase
          if (en) mm[k][i][8*l +: 8] = b_wdata[k][8*l +: 8];
        end
      end
      if (dl_of(k) == 1) begin
        nxt_dok = 1;
        if (!b_wr[k]) e_rd[k] = pend_d[k];
      end else begin
        pend_v[k] = 1;
        pend_c[k] = dl_of(k) - 1;
        pend_w[k] = b_wr[k];
      end
    end
    e_dok[k] = nxt_dok;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_only(input int k, input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input bit jitter);
    bit got;
    got        = 0;
    b_wr[k]    = w;
    b_size[k]  = sz;
    b_addr[k]  = a;
    b_wdata[k] = d;
    b_req[k]   = 1'b1;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      got = aok[k];
      step();
      if (!got && jitter) begin
        b_size[k]  = 2'($urandom_range(0, 3));
        b_wdata[k] = $urandom;
      end
    end
    b_req[k] = 1'b0;
    check($sformatf("handshake_seen[%0d]", k), 32'(got), 32'd1);
  endtask

  task automatic wait_resp(input int k, output logic [31:0] r);
    bit got;
    got = 0;
    r   = '0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (dok[k]) begin
        got = 1;
        r   = rd[k];
      end
      step();
    end
    check($sformatf("response_seen[%0d]", k), 32'(got), 32'd1);
  endtask

  task automatic do_req(input int k, input bit w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit jitter, output logic [31:0] r);
    hs_only(k, w, sz, a, d, jitter);
    wait_resp(k, r);
  endtask

  task automatic abandon(input int k, input int n, input logic [31:0] a, input logic [31:0] d);
    b_wr[k]    = 1'b1;
    b_size[k]  = 2'd2;
    b_addr[k]  = a;
    b_wdata[k] = d;
    b_req[k]   = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check($sformatf("abandon_addr_ok[%0d]", k), 32'(aok[k]), 32'd0);
      step();
    end
    b_req[k] = 1'b0;
    repeat (dl_of(k) + 2) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      b_rst[k]   = 1'b1;
      b_req[k]   = 1'b1;
      b_wr[k]    = 1'b0;
      b_size[k]  = 2'd2;
      b_addr[k]  = '0;
      b_wdata[k] = '0;
    end
    repeat (3) step();
    for (int k = 0; k < NI; k++) b_req[k] = 1'b0;
    step();
    for (int k = 0; k < NI; k++) b_rst[k] = 1'b0;
    step();

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 32; i++)
        do_req(k, 1'b1, 2'd2, 32'(i * 4), 32'hA500_0000 | 32'(i), 1'b0, r);

    // Word write then read
    do_req(0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, r);
    do_req(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, r);
    check("word_readback", r, 32'hDEAD_BEEF);

    // Byte and halfword lanes
    do_req(0, 1'b1, 2'd2, 32'h20, 32'h0000_0000, 1'b0, r);
    do_req(0, 1'b1, 2'd0, 32'h22, 32'h00AA_0000, 1'b0, r);
    do_req(0, 1'b1, 2'd1, 32'h20, 32'h0000_1234, 1'b0, r);
    do_req(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, r);
    check("byte_half_merge", r, 32'h00AA_1234);

    // Back-to-back reads at peak rate
    do_req(0, 1'b1, 2'd2, 32'h0, 32'd1, 1'b0, r);
    do_req(0, 1'b1, 2'd2, 32'h4, 32'd2, 1'b0, r);
    do_req(0, 1'b1, 2'd2, 32'h8, 32'd3, 1'b0, r);
    b_wr[0] = 1'b0; b_size[0] = 2'd2; b_req[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      b_addr[0] = 32'(j * 4);
      @(negedge clk);
      check("b2b_addr_ok", 32'(aok[0]), 32'd1);
      if (j > 0) begin
        check("b2b_data_ok", 32'(dok[0]), 32'd1);
        check("b2b_rdata", rd[0], 32'(j));
      end
      step();
    end
    b_req[0] = 1'b0;
    @(negedge clk);
    check("b2b_data_ok_last", 32'(dok[0]), 32'd1);
    check("b2b_rdata_last", rd[0], 32'd3);
    step();

    // ADDR_LAT=2, DATA_LAT=3 with req held
    b_wr[1] = 1'b1; b_size[1] = 2'd2; b_addr[1] = 32'h30; b_wdata[1] = 32'h1357_9BDF;
    b_req[1] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("lat_addr_ok_cycle%0d", c), 32'(aok[1]), (c == 3) ? 32'd1 : 32'd0);
      step();
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("lat_wait_addr_ok_%0d", c), 32'(aok[1]), 32'd0);
      check($sformatf("lat_data_ok_%0d", c), 32'(dok[1]), (c == 3) ? 32'd1 : 32'd0);
      step();
    end
    b_req[1] = 1'b0;
    step();
    do_req(1, 1'b0, 2'd2, 32'h30, 32'h0, 1'b0, r);
    check("lat_readback", r, 32'h1357_9BDF);

    // Abandoned request leaves memory alone
    abandon(2, 2, 32'h14, 32'hFFFF_FFFF);
    do_req(2, 1'b0, 2'd2, 32'h14, 32'h0, 1'b0, r);
    check("abandon_mem", r, 32'hA500_0005);

    // Reset during DATA_WAIT of a write
    hs_only(2, 1'b1, 2'd2, 32'h40, 32'h0000_0055, 1'b0);
    @(negedge clk);
    check("rst_pre_data_ok", 32'(dok[2]), 32'd0);
    step();
    b_rst[2] = 1'b1;
    @(negedge clk);
    check("rst_rdata", rd[2], 32'd0);
    check("rst_data_ok", 32'(dok[2]), 32'd0);
    step();
    b_rst[2] = 1'b0;
    repeat (6) step();
    do_req(2, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, r);
    check("rst_write_kept", r, 32'h0000_0055);

    // Randomized traffic with aliased upper address bits
    for (int k = 0; k < NI; k++) begin
      repeat (60) begin
        a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2)
            | 32'($urandom_range(0, 3));
        if (al_of(k) > 1 && $urandom_range(0, 7) == 0) begin
          abandon(k, $urandom_range(1, al_of(k) - 1), a, $urandom);
        end else begin
          do_req(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
                 1'b1, r);
        end
        repeat ($urandom_range(0, 2)) step();
      end
    end

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
